// File: rtl/rgb_seq.sv
// rgb_seq: colour sequencer feeding the rgb PWM colour register.
//
// Plays a table of up to DEPTH {hold, colour} entries. Each entry is shown
// for (hold+1) prescaler ticks, where one tick is TICK_DIV clk cycles.
// Playback is one-shot (ends with a done pulse) or looped.
//
// Optional build macro: RGB_SEQ_FADE_EN. When defined, each new entry fades
// in by stepping every 8-bit channel by 1 per tick before its hold starts.
//
// Ports:
//   clk, resetn          clock and synchronous active-low reset
//   cfg_we/addr/color/hold  table write port (addresses >= DEPTH ignored)
//   seq_len, seq_loop    active entry count and loop enable, sampled at start
//   start, stop          one-cycle playback control pulses (stop wins)
//   rgb_out, rgb_upd     current colour word and its change strobe
//   busy, idx, done      playback status, current entry, one-shot end pulse
module rgb_seq #(
    parameter int unsigned DEPTH    = 8,
    parameter int unsigned HOLD_W   = 16,
    parameter int unsigned TICK_DIV = 100000
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic                      cfg_we,
    input  logic [$clog2(DEPTH)-1:0]  cfg_addr,
    input  logic [23:0]               cfg_color,
    input  logic [HOLD_W-1:0]         cfg_hold,
    input  logic [$clog2(DEPTH):0]    seq_len,
    input  logic                      seq_loop,
    input  logic                      start,
    input  logic                      stop,
    output logic [23:0]               rgb_out,
    output logic                      rgb_upd,
    output logic                      busy,
    output logic [$clog2(DEPTH)-1:0]  idx,
    output logic                      done
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam int unsigned PW = $clog2(TICK_DIV);
    localparam int unsigned EW = HOLD_W + 24;

`ifdef RGB_SEQ_FADE_EN
    typedef enum logic [1:0] {StIdle, StLoad, StHold, StFade} state_e;
`else
    typedef enum logic [1:0] {StIdle, StLoad, StHold} state_e;
`endif

    state_e            state_q, state_d;
    logic [AW-1:0]     idx_q, idx_d;
    logic [LW-1:0]     len_q, len_d;
    logic              loop_q, loop_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [PW-1:0]     presc_q, presc_d;
    logic [23:0]       rgb_out_q, rgb_out_d;
    logic              rgb_upd_q, rgb_upd_d;
    logic              done_q, done_d;
`ifdef RGB_SEQ_FADE_EN
    logic [23:0]       target_q, target_d;
    logic [23:0]       faded;
`endif

    logic              busy_int;
    logic              tick;
    logic              start_ok;
    logic [LW-1:0]     len_clamp;
    logic [LW-1:0]     idx_next;
    logic [EW-1:0]     rd_data_q;
    logic [23:0]       rd_color;
    logic [HOLD_W-1:0] rd_hold;

    // Table RAM: not reset, registered read of the entry idx_d selects, so
    // the data for entry idx is valid while in LOAD.
    logic [EW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (cfg_we && (32'(cfg_addr) < DEPTH)) begin
            mem[cfg_addr] <= {cfg_hold, cfg_color};
        end
        rd_data_q <= mem[idx_d];
    end

    assign rd_color = rd_data_q[23:0];
    assign rd_hold  = rd_data_q[EW-1:24];

`ifdef RGB_SEQ_FADE_EN
    function automatic logic [7:0] step_ch(input logic [7:0] cur, input logic [7:0] tgt);
        if (cur < tgt) begin
            return cur + 8'd1;
        end else if (cur > tgt) begin
            return cur - 8'd1;
        end
        return cur;
    endfunction

    assign faded = {step_ch(rgb_out_q[23:16], target_q[23:16]),
                    step_ch(rgb_out_q[15:8],  target_q[15:8]),
                    step_ch(rgb_out_q[7:0],   target_q[7:0])};
`endif

    // State register
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q   <= StIdle;
            idx_q     <= '0;
            len_q     <= '0;
            loop_q    <= 1'b0;
            hold_q    <= '0;
            presc_q   <= '0;
            rgb_out_q <= '0;
            rgb_upd_q <= 1'b0;
            done_q    <= 1'b0;
`ifdef RGB_SEQ_FADE_EN
            target_q  <= '0;
`endif
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            len_q     <= len_d;
            loop_q    <= loop_d;
            hold_q    <= hold_d;
            presc_q   <= presc_d;
            rgb_out_q <= rgb_out_d;
            rgb_upd_q <= rgb_upd_d;
            done_q    <= done_d;
`ifdef RGB_SEQ_FADE_EN
            target_q  <= target_d;
`endif
        end
    end

    // Next-state logic
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        len_d     = len_q;
        loop_d    = loop_q;
        hold_d    = hold_q;
        rgb_out_d = rgb_out_q;
        done_d    = 1'b0;
`ifdef RGB_SEQ_FADE_EN
        target_d  = target_q;
`endif

        len_clamp = (32'(seq_len) > DEPTH) ? LW'(DEPTH) : seq_len;
        start_ok  = start && (len_clamp != '0);
        tick      = busy_int && (presc_q == PW'(TICK_DIV - 1));
        idx_next  = {1'b0, idx_q} + LW'(1);

        // Prescaler only runs while playing; a start realigns it.
        if (!busy_int || (start_ok && !stop)) begin
            presc_d = '0;
        end else if (tick) begin
            presc_d = '0;
        end else begin
            presc_d = presc_q + PW'(1);
        end

        if (stop) begin
            if (busy_int) begin
                state_d = StIdle;
                idx_d   = '0;
            end
        end else if (start_ok) begin
            state_d = StLoad;
            idx_d   = '0;
            len_d   = len_clamp;
            loop_d  = seq_loop;
        end else begin
            unique case (state_q)
                StIdle: ;
                StLoad: begin
                    hold_d = rd_hold;
`ifdef RGB_SEQ_FADE_EN
                    target_d = rd_color;
                    state_d  = StFade;
`else
                    rgb_out_d = rd_color;
                    state_d   = StHold;
`endif
                end
                StHold: begin
                    if (tick) begin
                        if (hold_q != '0) begin
                            hold_d = hold_q - HOLD_W'(1);
                        end else if (idx_next < len_q) begin
                            idx_d   = idx_next[AW-1:0];
                            state_d = StLoad;
                        end else if (loop_q) begin
                            idx_d   = '0;
                            state_d = StLoad;
                        end else begin
                            idx_d   = '0;
                            state_d = StIdle;
                            done_d  = 1'b1;
                        end
                    end
                end
`ifdef RGB_SEQ_FADE_EN
                StFade: begin
                    // The tick that lands on the target also starts the hold.
                    if (tick) begin
                        rgb_out_d = faded;
                        if (faded == target_q) begin
                            state_d = StHold;
                        end
                    end
                end
`endif
                default: state_d = StIdle;
            endcase
        end

        rgb_upd_d = (rgb_out_d != rgb_out_q);
    end

    // Outputs
    always_comb begin
        busy_int = (state_q != StIdle);
    end

    assign busy    = busy_int;
    assign idx     = idx_q;
    assign rgb_out = rgb_out_q;
    assign rgb_upd = rgb_upd_q;
    assign done    = done_q;

endmodule

// File: doc/rgb_seq.md
Name: rgb_seq

Overview:
- Colour sequencer for the `rgb` PWM block.
- Plays a programmed table of up to DEPTH colour entries, each with its own hold time, and presents the current 24-bit colour word to the `rgb` colour register.
- Sits between software configuration registers and `rgb`, replacing direct software writes for blink, cycle and breathe patterns.
- Supports one-shot or looped playback, start/stop control and a done strobe.

Parameters:
- DEPTH, 8, number of colour table entries (2..16).
- HOLD_W, 16, width of the per-entry hold counter, in ticks.
- TICK_DIV, 100000, clk cycles per sequencer tick (>=2). Sets the time base.

Ports:
- clk  in  1  system clock, same clock as the bus.
- resetn  in  1  synchronous active-low reset.
- cfg_we  in  1  table write strobe, one cycle.
- cfg_addr  in  $clog2(DEPTH)  table entry index.
- cfg_color  in  24  entry colour: [7:0]=R, [15:8]=G, [23:16]=B.
- cfg_hold  in  HOLD_W  entry hold time in ticks.
- seq_len  in  $clog2(DEPTH)+1  number of active entries; sampled at start.
- seq_loop  in  1  1 = wrap to entry 0 after the last entry; sampled at start.
- start  in  1  one-cycle pulse, begins playback from entry 0.
- stop  in  1  one-cycle pulse, aborts playback.
- rgb_out  out  24  current colour word to `rgb`.
- rgb_upd  out  1  one-cycle strobe whenever rgb_out changes.
- busy  out  1  high while playing.
- idx  out  $clog2(DEPTH)  index of the entry being played.
- done  out  1  one-cycle pulse at the end of one-shot playback.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous, active-low, on resetn.
- Reset values: rgb_out=0, rgb_upd=0, busy=0, idx=0, done=0, state=IDLE, prescaler=0. The table RAM is not reset; its contents are undefined until written.
- Table writes:
  - When cfg_we=1 and cfg_addr<DEPTH, {cfg_hold,cfg_color} is written next cycle.
  - cfg_addr>=DEPTH is ignored.
  - Writes are allowed while busy; a written entry takes effect the next time it is loaded.
- Length: seq_len is clamped to DEPTH. If the sampled value is 0, start is ignored.
- Prescaler:
  - Counts 0..TICK_DIV-1 only while busy.
  - tick=1 in the cycle the count equals TICK_DIV-1, then wraps to 0.
  - Cleared to 0 on start.
- States:
  - IDLE: busy=0. Exit to LOAD on start.
  - LOAD: read entry[idx]; set rgb_out=color and hold_cnt=hold. Go to HOLD (or FADE, see Optional Feature).
  - HOLD, on tick:
    - If hold_cnt!=0, decrement it.
    - Else advance: if idx+1<len then idx++ and go to LOAD.
    - Else if loop, idx=0 and go to LOAD.
    - Else go to IDLE with done=1 for one cycle.
- Start latency:
  - start in cycle N: busy=1 and idx=0 in N+1.
  - rgb_out=entry0 colour with rgb_upd=1 in N+2.
- Entry duration: each entry is displayed for (hold+1) ticks. hold=0 gives one tick.
- rgb_upd: pulses only if the new rgb_out differs from the old value. Loading an identical colour gives no strobe.
- stop:
  - Next cycle: state=IDLE, busy=0, idx=0.
  - rgb_out holds its last value; no done pulse.
  - stop in IDLE has no effect.
- Simultaneous events:
  - start and stop in the same cycle: stop wins.
  - start while busy: restart from entry 0 with a freshly sampled seq_len/seq_loop; prescaler cleared; no done pulse.
  - Reset mid-operation: all outputs return to reset values the next cycle, including rgb_out=0.
- Table read: synchronous single-port RAM, registered read, 1-cycle latency; this is accounted for in LOAD.

Optional Feature:
- Macro: RGB_SEQ_FADE_EN.
- When defined:
  - LOAD sets target=color and goes to FADE.
  - In FADE, on each tick every channel of rgb_out independently steps by 1 toward target (8-bit, no overshoot). rgb_upd pulses on each step.
  - When rgb_out==target, go to HOLD with hold_cnt=hold, in the same tick as the last step.
  - stop and start behave as in HOLD.
  - If rgb_out already equals target, FADE exits on the first tick.
- When undefined: no FADE state; colour changes are instantaneous; target logic and FADE are absent from the netlist.

Test Plan (TICK_DIV=4):
- Write entry0={00FF00,hold 2}, entry1={0000FF,hold 0}; len=2, loop=0; pulse start.
  - rgb_out=00FF00 for 12 clk.
  - Then 0000FF for 4 clk.
  - done pulses once; busy=0; rgb_out stays 0000FF.
- Same table with loop=1, run 40 clk.
  - Colours alternate 00FF00 and 0000FF every 12/4 clk.
  - idx sequence 0,1,0,1; done never asserts.
- Pulse stop mid-HOLD of entry1.
  - busy=0 and idx=0 next cycle; rgb_out=0000FF retained.
  - A later start restarts at entry 0.
- Edge cases:
  - len=0 with start: busy stays 0, no rgb_upd.
  - start and stop in the same cycle while IDLE: remains IDLE.
  - cfg_addr=DEPTH write: table unchanged on readback by playback.
- Two identical consecutive entries 123456: only one rgb_upd pulse.
  - Assert resetn=0 mid-run: next cycle rgb_out=0, busy=0.
- With RGB_SEQ_FADE_EN, from 000000 to entry {000003, hold 0}: rgb_out goes 000001, 000002, 000003 on successive ticks with 3 rgb_upd pulses, then holds for 1 tick.
